float_to_int: RTL and testbench
===============================

// Module: float_to_int
// PURPOSE
//  Sequential IEEE-754 float -> signed two's-complement integer converter. Decode-side counterpart of the float_ops unit.
//  Unpacks sign/exponent/mantissa, shifts the mantissa one bit per clock into integer position, then applies the sign.
//  Sits between float_ops results and integer consumers (display, DAC, counters). Uses the same in_start/out_ready handshake as float_ops.
// PARAMETERS
//  BITS      32  float width (16 for half precision)
//  EXP_BITS  8   exponent width (5 for half); MANT_BITS = BITS-1-EXP_BITS, BIAS = 2**(EXP_BITS-1)-1
//  INT_BITS  32  output integer width (>=2)
// PORTS
//  in_clk       in   1         clock, all state updates on rising edge
//  in_rst       in   1         asynchronous, active-low reset
//  in_start     in   1         request conversion of in_a
//  in_a         in   BITS      float operand
//  out_ready    out  1         result valid
//  out_result   out  INT_BITS  signed integer result
//  out_ovf      out  1         magnitude out of range or +-inf; result saturated
//  out_invalid  out  1         NaN input; result 0
// BEHAVIOUR
//  - Reset (in_rst=0, any time, including mid-conversion): state IDLE; out_ready=0, out_result=0, out_ovf=0, out_invalid=0; internal regs cleared.
//  - States: IDLE -> UNPACK -> SHIFT -> [ROUND] -> SIGN -> READY.
//    - IDLE: on in_start=1, latch in_a and go to UNPACK. in_a is ignored outside IDLE.
//  - UNPACK: E = exp - BIAS (signed, EXP_BITS+1 bits); acc (INT_BITS+MANT_BITS+1 bits) <= {0, 1, frac}; cnt <= E.
//    - exp all ones, frac != 0: out_invalid=1, magnitude 0, go to SIGN.
//    - exp all ones, frac == 0: out_ovf=1, saturate, go to SIGN.
//    - exp == 0 (zero/subnormal), or E < 0: magnitude 0, go to SIGN. With rounding, E == -1 instead goes to ROUND.
//    - E >= INT_BITS-1: overflow. Exception: negative with E == INT_BITS-1 and frac == 0 gives exact -2**(INT_BITS-1), no flag.
//    - Otherwise go to SHIFT.
//  - SHIFT: acc <= acc << 1, cnt <= cnt-1 each clock while cnt != 0 (E cycles; 0 cycles when E == 0).
//  - Integer part = acc >> MANT_BITS; fraction = acc[MANT_BITS-1:0]. Without rounding, go to SIGN (truncate toward zero).
//  - SIGN: result = sign ? -mag : mag. Saturation: +max 2**(INT_BITS-1)-1, or -2**(INT_BITS-1) when negative.
//  - READY: out_ready=1; out_result and flags held stable. Stay while in_start=1; go to IDLE when in_start=0, which clears out_ready.
//  - Latency: start sampled at edge 0. out_ready is high after edge E+3 for normal inputs (E+4 with rounding), and after edge 2 for special/zero inputs.
//  - Back-to-back requests: in_start must drop for >= 1 cycle between conversions.
// CONFIGURATION
//  FLOAT_TO_INT_ROUND_EN defined:
//    - ROUND state, round-to-nearest-even on the fraction (half = 1<<(MANT_BITS-1), ties to even integer).
//    - A round-up that reaches 2**(INT_BITS-1) saturates with out_ovf (negative exactly -2**(INT_BITS-1) excepted).
//  Not defined: no ROUND state; truncation toward zero.
// STRUCTURE
//  - Package float_pkg: state enum t_f2i_state; localparam functions for MANT_BITS, BIAS, exponent all-ones mask.
//  - Sub-module float_unpack (combinational): splits in_a into sign, exponent, fraction and is_nan/is_inf/is_zero.
//  - Everything else (FSM, acc, cnt) lives in this module.
// TESTING (BITS=32, EXP_BITS=8, INT_BITS=32)
//  - 0x42c80000 (100.0) -> 0x00000064, E=6, out_ready after edge 9; no flags.
//  - 0xbf9d70a3 (-1.23) -> 0xffffffff; 0x4015c28f (2.34) -> 0x00000002.
//  - 0x40600000 (3.5): 3 truncating, 4 rounding. 0x40200000 (2.5): 2 both. 0x3f400000 (0.75): 0 truncating, 1 rounding.
//  - 0x4f32d05e (3e9) -> 0x7fffffff, out_ovf=1. 0xcf000000 -> 0x80000000, out_ovf=0. 0xff800000 -> 0x80000000, out_ovf=1.
//  - 0x7fc00000 (NaN) -> 0, out_invalid=1. 0x00000001 (subnormal) -> 0, no flags, ready after edge 2.
//  - Assert in_rst=0 during SHIFT of 0x4e800000: all outputs 0 immediately. Reconvert after reset gives 0x40000000 (2**30).

Source files
------------

// File: rtl/float_pkg.sv
// ---------------------------------------------------------------------------
// float_pkg
//  Shared definitions for the float -> integer conversion path.
//  - t_f2i_state : state encoding of the float_to_int sequencer
//  - mant_bits() : fraction width for a given float width / exponent width
//  - exp_bias()  : exponent bias, 2**(EXP_BITS-1)-1
//  - exp_ones()  : all-ones exponent value (inf / NaN marker)
// ---------------------------------------------------------------------------
package float_pkg;

   typedef enum logic [2:0] {
      F2I_IDLE,
      F2I_UNPACK,
      F2I_SHIFT,
      F2I_ROUND,
      F2I_SIGN,
      F2I_READY
   } t_f2i_state;

   function automatic int mant_bits(input int bits, input int exp_bits);
      return bits - 1 - exp_bits;
   endfunction

   function automatic int exp_bias(input int exp_bits);
      return (1 << (exp_bits - 1)) - 1;
   endfunction

   function automatic int exp_ones(input int exp_bits);
      return (1 << exp_bits) - 1;
   endfunction

endpackage

// File: rtl/float_unpack.sv
// ---------------------------------------------------------------------------
// float_unpack
//  Combinational split of an IEEE-754 word into its fields plus class flags.
//  Ports:
//   a        in   BITS             float operand
//   sign     out  1                sign bit
//   expo     out  EXP_BITS         biased exponent field
//   frac     out  MANT_BITS        fraction field (hidden bit not included)
//   is_nan   out  1                exponent all ones, fraction non-zero
//   is_inf   out  1                exponent all ones, fraction zero
//   is_zero  out  1                exponent zero (zero or subnormal)
// ---------------------------------------------------------------------------
module float_unpack
   import float_pkg::*;
#(
   parameter int BITS     = 32,
   parameter int EXP_BITS = 8
) (
   input  logic [BITS-1:0]                         a,
   output logic                                    sign,
   output logic [EXP_BITS-1:0]                     expo,
   output logic [mant_bits(BITS, EXP_BITS)-1:0]    frac,
   output logic                                    is_nan,
   output logic                                    is_inf,
   output logic                                    is_zero
);

   localparam int                  MANT_BITS = mant_bits(BITS, EXP_BITS);
   localparam logic [EXP_BITS-1:0] EXP_ONES  = EXP_BITS'(exp_ones(EXP_BITS));

   logic exp_max;

   assign sign    = a[BITS-1];
   assign expo    = a[BITS-2 -: EXP_BITS];
   assign frac    = a[MANT_BITS-1:0];
   assign exp_max = (expo == EXP_ONES);
   assign is_nan  = exp_max && (frac != '0);
   assign is_inf  = exp_max && (frac == '0);
   assign is_zero = (expo == '0);

endmodule

// File: rtl/float_to_int.sv
// ---------------------------------------------------------------------------
// float_to_int
//  Sequential IEEE-754 float -> signed two's-complement integer converter.
//  The mantissa (with hidden bit) is shifted left one bit per clock until the
//  binary point sits at bit MANT_BITS, then the sign is applied.
//  Optional feature macro: FLOAT_TO_INT_ROUND_EN
//   defined     : extra ROUND state, round-to-nearest-even on the fraction
//   not defined : truncation toward zero
//  Ports:
//   in_clk       in   1         clock, rising edge
//   in_rst       in   1         asynchronous reset, active low
//   in_start     in   1         request conversion of in_a (sampled in IDLE)
//   in_a         in   BITS      float operand
//   out_ready    out  1         result valid, held until in_start drops
//   out_result   out  INT_BITS  signed integer result
//   out_ovf      out  1         out of range or +-inf, result saturated
//   out_invalid  out  1         NaN input, result 0
// ---------------------------------------------------------------------------
module float_to_int
   import float_pkg::*;
#(
   parameter int BITS     = 32,
   parameter int EXP_BITS = 8,
   parameter int INT_BITS = 32
) (
   input  logic                       in_clk,
   input  logic                       in_rst,
   input  logic                       in_start,
   input  logic [BITS-1:0]            in_a,
   output logic                       out_ready,
   output logic signed [INT_BITS-1:0] out_result,
   output logic                       out_ovf,
   output logic                       out_invalid
);

   localparam int MANT_BITS = mant_bits(BITS, EXP_BITS);
   localparam int BIAS      = exp_bias(EXP_BITS);
   localparam int ACC_W     = INT_BITS + MANT_BITS + 1;

   localparam logic signed [EXP_BITS:0]   BIAS_S  = (EXP_BITS+1)'(BIAS);
   localparam logic signed [INT_BITS-1:0] INT_MAX = {1'b0, {(INT_BITS-1){1'b1}}};
   localparam logic signed [INT_BITS-1:0] INT_MIN = {1'b1, {(INT_BITS-1){1'b0}}};

   t_f2i_state               state;
   logic [BITS-1:0]          a_r;
   logic [ACC_W-1:0]         acc;
   logic [EXP_BITS:0]        cnt;
   logic                     sat_r;

   logic                     u_sign;
   logic [EXP_BITS-1:0]      u_expo;
   logic [MANT_BITS-1:0]     u_frac;
   logic                     u_nan;
   logic                     u_inf;
   logic                     u_zero;

   logic signed [EXP_BITS:0] e_val;
   int                       e_int;

   // The latched operand stays stable for the whole conversion, so the
   // field split can stay combinational and feed every state directly.
   float_unpack #(
      .BITS     (BITS),
      .EXP_BITS (EXP_BITS)
   ) u_unpack (
      .a       (a_r),
      .sign    (u_sign),
      .expo    (u_expo),
      .frac    (u_frac),
      .is_nan  (u_nan),
      .is_inf  (u_inf),
      .is_zero (u_zero)
   );

   assign e_val = $signed({1'b0, u_expo}) - BIAS_S;
   assign e_int = int'(e_val);

   // Final result from magnitude and sign; sat selects the rail by sign.
   // The magnitude carries one spare bit so that 2**(INT_BITS-1) negates
   // cleanly to the most negative integer.
   function automatic logic signed [INT_BITS-1:0] apply_sign(
      input logic                neg,
      input logic                sat,
      input logic [INT_BITS:0]   mag
   );
      if (sat)
         return neg ? INT_MIN : INT_MAX;
      return neg ? INT_BITS'(-mag) : INT_BITS'(mag);
   endfunction

`ifdef FLOAT_TO_INT_ROUND_EN
   localparam logic [MANT_BITS-1:0] HALF = {1'b1, {(MANT_BITS-1){1'b0}}};

   // Round-to-nearest-even of the fixed-point accumulator.
   function automatic logic [INT_BITS:0] round_rne(input logic [ACC_W-1:0] a);
      logic [INT_BITS:0]    ip;
      logic [MANT_BITS-1:0] fr;
      logic                 up;
      ip = a[ACC_W-1:MANT_BITS];
      fr = a[MANT_BITS-1:0];
      up = (fr > HALF) || ((fr == HALF) && ip[0]);
      return ip + (INT_BITS+1)'(up);
   endfunction

   logic [INT_BITS:0] rnd_mag;
   always_comb rnd_mag = round_rne(acc);
`endif

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state       <= F2I_IDLE;
         a_r         <= '0;
         acc         <= '0;
         cnt         <= '0;
         sat_r       <= 1'b0;
         out_ready   <= 1'b0;
         out_result  <= '0;
         out_ovf     <= 1'b0;
         out_invalid <= 1'b0;
      end else begin
         case (state)
            F2I_IDLE: begin
               if (in_start) begin
                  a_r         <= in_a;
                  sat_r       <= 1'b0;
                  out_result  <= '0;
                  out_ovf     <= 1'b0;
                  out_invalid <= 1'b0;
                  state       <= F2I_UNPACK;
               end
            end

            F2I_UNPACK: begin
               acc   <= {{INT_BITS{1'b0}}, 1'b1, u_frac};
               cnt   <= $unsigned(e_val);
               state <= F2I_SHIFT;
               if (u_nan) begin
                  out_invalid <= 1'b1;
                  acc         <= '0;
                  state       <= F2I_SIGN;
               end else if (u_inf) begin
                  out_ovf <= 1'b1;
                  sat_r   <= 1'b1;
                  state   <= F2I_SIGN;
               end else if (u_zero || (e_int < 0)) begin
`ifdef FLOAT_TO_INT_ROUND_EN
                  // Values in [0.5,1) still matter for rounding: place them
                  // one bit below the binary point, folding the dropped LSB
                  // into a sticky bit so exact halves stay distinguishable.
                  if (!u_zero && (e_int == -1)) begin
                     acc   <= {{(INT_BITS+1){1'b0}}, 1'b1, u_frac[MANT_BITS-1:1]}
                              | ACC_W'(u_frac[0]);
                     state <= F2I_ROUND;
                  end else begin
                     acc   <= '0;
                     state <= F2I_SIGN;
                  end
`else
                  acc   <= '0;
                  state <= F2I_SIGN;
`endif
               end else if (e_int >= INT_BITS - 1) begin
                  // -2**(INT_BITS-1) is representable exactly, no flag.
                  sat_r   <= 1'b1;
                  out_ovf <= !(u_sign && (e_int == INT_BITS - 1) && (u_frac == '0));
                  state   <= F2I_SIGN;
               end
            end

            F2I_SHIFT: begin
               if (cnt != '0) begin
                  acc <= acc << 1;
                  cnt <= cnt - (EXP_BITS+1)'(1);
               end else begin
`ifdef FLOAT_TO_INT_ROUND_EN
                  state <= F2I_ROUND;
`else
                  state <= F2I_SIGN;
`endif
               end
            end

`ifdef FLOAT_TO_INT_ROUND_EN
            F2I_ROUND: begin
               acc <= {rnd_mag, {MANT_BITS{1'b0}}};
               // A round-up can only reach exactly 2**(INT_BITS-1).
               if (rnd_mag[INT_BITS:INT_BITS-1] != 2'b00) begin
                  sat_r   <= 1'b1;
                  out_ovf <= !u_sign;
               end
               state <= F2I_SIGN;
            end
`endif

            F2I_SIGN: begin
               out_result <= apply_sign(u_sign, sat_r, acc[ACC_W-1:MANT_BITS]);
               out_ready  <= 1'b1;
               state      <= F2I_READY;
            end

            F2I_READY: begin
               if (!in_start) begin
                  out_ready <= 1'b0;
                  state     <= F2I_IDLE;
               end
            end

            default: state <= F2I_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float_to_int.sv
// ---------------------------------------------------------------------------
// tb_float_to_int
//  Scoreboard bench for float_to_int (BITS=32, EXP_BITS=8, INT_BITS=32).
//  The stimulus process issues conversions and queues the expected response
//  from a real-arithmetic reference model; the monitor process compares the
//  DUT output (value, flags, latency, hold stability) whenever out_ready rises.
// ---------------------------------------------------------------------------
module tb_float_to_int;

`ifdef FLOAT_TO_INT_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] res;
      logic        ovf;
      logic        inv;
      int          lat;
      int          start;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic               in_start;
   logic [31:0]        in_a;
   logic               out_ready;
   logic signed [31:0] out_result;
   logic               out_ovf;
   logic               out_invalid;

   exp_t   q[$];
   int     cyc;
   int     checks;
   int     failures;

   float_to_int #(
      .BITS     (32),
      .EXP_BITS (8),
      .INT_BITS (32)
   ) dut (
      .in_clk      (clk),
      .in_rst      (rst_n),
      .in_start    (in_start),
      .in_a        (in_a),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_ovf     (out_ovf),
      .out_invalid (out_invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Reference model: value of the float in real arithmetic, then
   // truncate or round-half-even, then saturate to the int32 range.
   function automatic exp_t model(input logic [31:0] a);
      exp_t   r;
      int     e;
      int     ue;
      longint f;
      bit     s;
      real    m;
      real    t;
      real    fr;
      longint mag;
      r.a     = a;
      r.res   = 32'h0;
      r.ovf   = 1'b0;
      r.inv   = 1'b0;
      r.start = 0;
      s  = a[31];
      e  = int'(a[30:23]);
      f  = longint'(a[22:0]);
      ue = e - 127;
      if (e == 255) begin
         r.lat = 2;
         if (f != 0) r.inv = 1'b1;
         else begin
            r.ovf = 1'b1;
            r.res = s ? 32'h80000000 : 32'h7fffffff;
         end
         return r;
      end
      if (e == 0 || ue < -1 || (ue == -1 && !ROUND) || ue >= 31) r.lat = 2;
      else r.lat = ue + 3 + (ROUND ? 1 : 0);
      if (e == 0) m = real'(f) * (2.0 ** (-149));
      else        m = (1.0 + real'(f) / 8388608.0) * (2.0 ** ue);
      t  = $floor(m);
      fr = m - t;
      if (m >= 4294967296.0) mag = 64'd4294967296;
      else                   mag = longint'(t);
      if (ROUND && (fr > 0.5 || (fr == 0.5 && (mag % 2) == 1))) mag++;
      if (!s && mag > 64'd2147483647) begin
         r.ovf = 1'b1;
         r.res = 32'h7fffffff;
      end else if (s && mag > 64'd2147483648) begin
         r.ovf = 1'b1;
         r.res = 32'h80000000;
      end else begin
         r.res = 32'(s ? -mag : mag);
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_float();
      int          k;
      int          ue;
      logic [22:0] fr;
      k = $urandom_range(0, 9);
      if (k < 6) begin
         return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 160)), 23'($urandom())};
      end else if (k == 6) begin
         fr = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom());
         return {1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 8'hff : 8'h00, fr};
      end else if (k < 9) begin
         // n + 0.5 style values to hit rounding ties
         ue = $urandom_range(0, 12);
         fr = 23'($urandom());
         fr = fr & ({23{1'b1}} << (22 - ue));
         fr[22-ue] = 1'b1;
         return {1'($urandom_range(0, 1)), 8'(127 + ue), fr};
      end
      return $urandom();
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      bit          seen;
      exp_t        e;
      logic [31:0] h_res;
      logic        h_ovf;
      logic        h_inv;
      seen = 0;
      h_res = '0;
      h_ovf = 0;
      h_inv = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_ready",   32'(out_ready),   32'h0);
            check("rst_result",  out_result,       32'h0);
            check("rst_ovf",     32'(out_ovf),     32'h0);
            check("rst_invalid", 32'(out_invalid), 32'h0);
            q.delete();
            seen = 0;
         end else if (out_ready) begin
            if (!seen) begin
               seen = 1;
               if (q.size() == 0) begin
                  check("unexpected_ready", 32'(out_ready), 32'h0);
               end else begin
                  e = q.pop_front();
                  check($sformatf("result[%h]", e.a),  out_result,       e.res);
                  check($sformatf("ovf[%h]", e.a),     32'(out_ovf),     32'(e.ovf));
                  check($sformatf("invalid[%h]", e.a), 32'(out_invalid), 32'(e.inv));
                  check($sformatf("latency[%h]", e.a), 32'(cyc - e.start), 32'(e.lat));
               end
               h_res = out_result;
               h_ovf = out_ovf;
               h_inv = out_invalid;
            end else begin
               check("hold_result", out_result, h_res);
               check("hold_flags", {30'h0, out_ovf, out_invalid}, {30'h0, h_ovf, h_inv});
            end
         end else begin
            seen = 0;
            if (q.size() > 0 && cyc > q[0].start + 100) begin
               e = q.pop_front();
               check($sformatf("timeout_ready[%h]", e.a), 32'(out_ready), 32'h1);
            end
         end
      end
   end

   // Issue one conversion; called at a falling edge.
   task automatic convert(input logic [31:0] a);
      exp_t e;
      e = model(a);
      e.start = cyc + 1;
      q.push_back(e);
      in_a     = a;
      in_start = 1'b1;
      @(negedge clk);
      in_a = $urandom();   // must be ignored once the conversion is running
      for (int i = 0; i < 120 && !out_ready; i++) @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_start = 1'b0;
      @(negedge clk);
   endtask

   logic [31:0] dir_vec [18] = '{
      32'h42c80000, 32'hbf9d70a3, 32'h4015c28f, 32'h40600000, 32'h40200000,
      32'h3f400000, 32'h4f32d05e, 32'hcf000000, 32'hff800000, 32'h7fc00000,
      32'h00000001, 32'h7f800000, 32'h3f000000, 32'h3f800000, 32'h4f000000,
      32'hcf000001, 32'h80000000, 32'h4effffff
   };

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      in_start = 1'b0;
      in_a     = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (dir_vec[i]) convert(dir_vec[i]);
      for (int i = 0; i < 150; i++) convert(rand_float());

      // Reset in the middle of the SHIFT phase of 2**30
      in_a     = 32'h4e800000;
      in_start = 1'b1;
      @(negedge clk);
      in_start = 1'b0;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      convert(32'h4e800000);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
